otter_cu_fsm: RTL and testbench

Multicycle control-unit state machine for the OTTER MCU. It sequences every instruction through fetch, execute, optional writeback and interrupt entry. It generates the write and read enables for the PC, register file, memory and CSR file, and the int_taken strobe that steers the decoder's PC-source mux. It sits beside the combinational decoder in the top-level OTTER wrapper.

---
 rtl/otter_cu_fsm_if.sv | 44 ++++
 rtl/otter_cu_fsm.sv | 144 ++++++++++++++
 tb/tb_otter_cu_fsm.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/otter_cu_fsm_if.sv
// Control-unit bundle: decoder/datapath side is master, the sequencing FSM is slave.
// mem_ready exists only when OTTER_MEM_WAIT_EN is defined.
interface otter_cu_fsm_if;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       intr;
`ifdef OTTER_MEM_WAIT_EN
    logic       mem_ready;
`endif
    logic       PCWrite;
    logic       regWrite;
    logic       memWE2;
    logic       memRDEN1;
    logic       memRDEN2;
    logic       reset;
    logic       csr_WE;
    logic       int_taken;
    logic       mret_exec;
    logic [2:0] state;

`ifdef OTTER_MEM_WAIT_EN
    modport master (
        output opcode, funct3, intr, mem_ready,
        input  PCWrite, regWrite, memWE2, memRDEN1, memRDEN2,
        input  reset, csr_WE, int_taken, mret_exec, state
    );
    modport slave (
        input  opcode, funct3, intr, mem_ready,
        output PCWrite, regWrite, memWE2, memRDEN1, memRDEN2,
        output reset, csr_WE, int_taken, mret_exec, state
    );
`else
    modport master (
        output opcode, funct3, intr,
        input  PCWrite, regWrite, memWE2, memRDEN1, memRDEN2,
        input  reset, csr_WE, int_taken, mret_exec, state
    );
    modport slave (
        input  opcode, funct3, intr,
        output PCWrite, regWrite, memWE2, memRDEN1, memRDEN2,
        output reset, csr_WE, int_taken, mret_exec, state
    );
`endif
endinterface

// File: rtl/otter_cu_fsm.sv
// OTTER multicycle control FSM: 2 cycles per instruction, 3 for loads, +1 for interrupt entry.
// OTTER_MEM_WAIT_EN adds mem_ready stalls in FETCH and in load/store EXEC; RST overrides any stall.
module otter_cu_fsm #(
    parameter int INIT_CYCLES = 1
) (
    input  logic          CLK,
    input  logic          RST,
    otter_cu_fsm_if.slave bus
);
    localparam logic [2:0] ST_INIT  = 3'd0;
    localparam logic [2:0] ST_FETCH = 3'd1;
    localparam logic [2:0] ST_EXEC  = 3'd2;
    localparam logic [2:0] ST_WB    = 3'd3;
    localparam logic [2:0] ST_INTR  = 3'd4;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_SYS    = 7'b1110011;

    localparam logic [3:0] INIT_LAST = 4'(INIT_CYCLES - 1);

    logic [2:0] state_q, state_d;
    logic [3:0] init_cnt_q, init_cnt_d;
    logic       mem_rdy;
    logic       is_load, is_store;

`ifdef OTTER_MEM_WAIT_EN
    assign mem_rdy = bus.mem_ready;
`else
    assign mem_rdy = 1'b1;
`endif

    assign is_load  = (bus.opcode == OP_LOAD);
    assign is_store = (bus.opcode == OP_STORE);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= ST_INIT;
            init_cnt_q <= 4'd0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
        end
    end

    always_comb begin
        state_d    = ST_INIT;
        init_cnt_d = 4'd0;
        case (state_q)
            ST_INIT: begin
                if (init_cnt_q == INIT_LAST) begin
                    state_d = ST_FETCH;
                end else begin
                    state_d    = ST_INIT;
                    init_cnt_d = init_cnt_q + 4'd1;
                end
            end
            ST_FETCH: state_d = mem_rdy ? ST_EXEC : ST_FETCH;
            ST_EXEC: begin
                // A load never samples intr here: its last cycle is WB.
                if (is_load)
                    state_d = mem_rdy ? ST_WB : ST_EXEC;
                else if (is_store && !mem_rdy)
                    state_d = ST_EXEC;
                else
                    state_d = bus.intr ? ST_INTR : ST_FETCH;
            end
            ST_WB:   state_d = bus.intr ? ST_INTR : ST_FETCH;
            ST_INTR: state_d = ST_FETCH;
            default: state_d = ST_INIT;
        endcase
    end

    logic pc_write, reg_write, mem_we2, mem_rden1, mem_rden2;
    logic dp_reset, csr_we, int_tkn, mret_ex;

    always_comb begin
        pc_write  = 1'b0;
        reg_write = 1'b0;
        mem_we2   = 1'b0;
        mem_rden1 = 1'b0;
        mem_rden2 = 1'b0;
        dp_reset  = 1'b0;
        csr_we    = 1'b0;
        int_tkn   = 1'b0;
        mret_ex   = 1'b0;
        case (state_q)
            ST_INIT:  dp_reset  = 1'b1;
            ST_FETCH: mem_rden1 = 1'b1;
            ST_EXEC: begin
                case (bus.opcode)
                    OP_LOAD:  mem_rden2 = 1'b1;
                    OP_STORE: begin
                        mem_we2  = 1'b1;
                        pc_write = mem_rdy;
                    end
                    OP_BRANCH: pc_write = 1'b1;
                    OP_REG, OP_IMM, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR: begin
                        pc_write  = 1'b1;
                        reg_write = 1'b1;
                    end
                    OP_SYS: begin
                        pc_write = 1'b1;
                        if (bus.funct3 == 3'b000) begin
                            mret_ex = 1'b1;
                        end else if (bus.funct3 == 3'b001 || bus.funct3 == 3'b010 ||
                                     bus.funct3 == 3'b011) begin
                            reg_write = 1'b1;
                            csr_we    = 1'b1;
                        end
                    end
                    default: pc_write = 1'b1;
                endcase
            end
            ST_WB: begin
                reg_write = 1'b1;
                pc_write  = 1'b1;
            end
            ST_INTR: begin
                int_tkn  = 1'b1;
                pc_write = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.PCWrite   = pc_write;
    assign bus.regWrite  = reg_write;
    assign bus.memWE2    = mem_we2;
    assign bus.memRDEN1  = mem_rden1;
    assign bus.memRDEN2  = mem_rden2;
    assign bus.reset     = dp_reset;
    assign bus.csr_WE    = csr_we;
    assign bus.int_taken = int_tkn;
    assign bus.mret_exec = mret_ex;
    assign bus.state     = state_q;
endmodule

// File: tb/tb_otter_cu_fsm.sv
// Bench for otter_cu_fsm: fixed vectors, hand sequences and randomized instruction streams.
`timescale 1ns/1ps
module tb_otter_cu_fsm;
    localparam int INIT_N = 3;
    localparam logic [8:0] O_PCW  = 9'h100;
    localparam logic [8:0] O_RW   = 9'h080;
    localparam logic [8:0] O_WE2  = 9'h040;
    localparam logic [8:0] O_RD1  = 9'h020;
    localparam logic [8:0] O_RD2  = 9'h010;
    localparam logic [8:0] O_RST  = 9'h008;
    localparam logic [8:0] O_CSR  = 9'h004;
    localparam logic [8:0] O_INT  = 9'h002;
    localparam logic [8:0] O_MRET = 9'h001;

    localparam logic [6:0] LOAD  = 7'b0000011;
    localparam logic [6:0] STORE = 7'b0100011;

    logic clk = 1'b0;
    logic rst;
    int   tests = 0;
    int   fails = 0;

    otter_cu_fsm_if bus();
    otter_cu_fsm #(.INIT_CYCLES(INIT_N)) dut (.CLK(clk), .RST(rst), .bus(bus.slave));

    always #5 clk = ~clk;

    logic [8:0] outs_w;
    assign outs_w = {bus.PCWrite, bus.regWrite, bus.memWE2, bus.memRDEN1, bus.memRDEN2,
                     bus.reset, bus.csr_WE, bus.int_taken, bus.mret_exec};

    typedef struct {
        logic [6:0] op;
        logic [2:0] f3;
        logic       intr;
        logic [8:0] exp_out;
        logic [2:0] exp_next;
    } vec_t;

    typedef struct {
        logic [2:0] st;
        logic [8:0] outs;
        logic       intr;
        logic       rdy;
    } cyc_t;

    vec_t vecs[19];
    cyc_t sched[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic set_rdy(input logic r);
`ifdef OTTER_MEM_WAIT_EN
        bus.mem_ready = r;
`else
        if (r === 1'bx) $display("note: ready level unknown");
`endif
    endtask

    function automatic int n_waits();
`ifdef OTTER_MEM_WAIT_EN
        return int'($urandom_range(0, 2));
`else
        return 0;
`endif
    endfunction

    function automatic logic rbit();
        return 1'($urandom);
    endfunction

    // Enables expected in the single EXEC cycle of a non-stalled instruction.
    function automatic logic [8:0] exec_outs(input logic [6:0] op, input logic [2:0] f3);
        case (op)
            7'b0000011: return O_RD2;
            7'b0100011: return O_WE2 | O_PCW;
            7'b1100011: return O_PCW;
            7'b0110011, 7'b0010011, 7'b0110111,
            7'b0010111, 7'b1101111, 7'b1100111: return O_PCW | O_RW;
            7'b1110011: begin
                if (f3 == 3'd0) return O_PCW | O_MRET;
                if (f3 >= 3'd1 && f3 <= 3'd3) return O_PCW | O_RW | O_CSR;
                return O_PCW;
            end
            default: return O_PCW;
        endcase
    endfunction

    logic [6:0] ops [12];

    initial begin
        vecs[0]  = '{7'b0110011, 3'b000, 1'b0, O_PCW | O_RW,          3'd1};
        vecs[1]  = '{7'b0000011, 3'b010, 1'b1, O_RD2,                 3'd3};
        vecs[2]  = '{7'b0100011, 3'b010, 1'b0, O_WE2 | O_PCW,         3'd1};
        vecs[3]  = '{7'b1100011, 3'b000, 1'b0, O_PCW,                 3'd1};
        vecs[4]  = '{7'b0010011, 3'b000, 1'b1, O_PCW | O_RW,          3'd4};
        vecs[5]  = '{7'b0110111, 3'b000, 1'b0, O_PCW | O_RW,          3'd1};
        vecs[6]  = '{7'b0010111, 3'b000, 1'b0, O_PCW | O_RW,          3'd1};
        vecs[7]  = '{7'b1101111, 3'b000, 1'b1, O_PCW | O_RW,          3'd4};
        vecs[8]  = '{7'b1100111, 3'b000, 1'b0, O_PCW | O_RW,          3'd1};
        vecs[9]  = '{7'b1110011, 3'b010, 1'b0, O_PCW | O_RW | O_CSR,  3'd1};
        vecs[10] = '{7'b1110011, 3'b001, 1'b0, O_PCW | O_RW | O_CSR,  3'd1};
        vecs[11] = '{7'b1110011, 3'b011, 1'b0, O_PCW | O_RW | O_CSR,  3'd1};
        vecs[12] = '{7'b1110011, 3'b000, 1'b0, O_PCW | O_MRET,        3'd1};
        vecs[13] = '{7'b1110011, 3'b000, 1'b1, O_PCW | O_MRET,        3'd4};
        vecs[14] = '{7'b1110011, 3'b100, 1'b0, O_PCW,                 3'd1};
        vecs[15] = '{7'b1110011, 3'b111, 1'b1, O_PCW,                 3'd4};
        vecs[16] = '{7'b0000000, 3'b000, 1'b0, O_PCW,                 3'd1};
        vecs[17] = '{7'b0100011, 3'b000, 1'b1, O_WE2 | O_PCW,         3'd4};
        vecs[18] = '{7'b1100011, 3'b001, 1'b1, O_PCW,                 3'd4};
        ops = '{7'b0000011, 7'b0100011, 7'b1100011, 7'b0110011, 7'b0010011, 7'b0110111,
                7'b0010111, 7'b1101111, 7'b1100111, 7'b1110011, 7'b1110011, 7'b0001111};

        // Reset: two cycles held, then INIT_N cycles in INIT after release.
        rst = 1'b1;
        bus.intr = 1'b0;
        bus.opcode = 7'd0;
        bus.funct3 = 3'd0;
        set_rdy(1'b1);
        step();
        step();
        check("rst_held_state", bus.state, 3'd0);
        check("rst_held_outs", outs_w, O_RST);
        rst = 1'b0;
        for (int i = 0; i < INIT_N; i++) begin
            check($sformatf("init%0d_state", i), bus.state, 3'd0);
            check($sformatf("init%0d_reset", i), bus.reset, 1'b1);
            step();
        end
        check("init_done_state", bus.state, 3'd1);
        check("init_done_outs", outs_w, O_RD1);

        // Fixed vectors, each starting from FETCH.
        for (int i = 0; i < 19; i++) begin
            bus.opcode = vecs[i].op;
            bus.funct3 = vecs[i].f3;
            bus.intr = 1'b0;
            #1;
            check($sformatf("vec%0d_fetch", i), bus.state, 3'd1);
            step();
            bus.intr = vecs[i].intr;
            #1;
            check($sformatf("vec%0d_exec_state", i), bus.state, 3'd2);
            check($sformatf("vec%0d_exec_outs", i), outs_w, vecs[i].exp_out);
            step();
            check($sformatf("vec%0d_next", i), bus.state, vecs[i].exp_next);
            if (vecs[i].exp_next == 3'd3) begin
                bus.intr = 1'b0;
                #1;
                check($sformatf("vec%0d_wb_outs", i), outs_w, O_PCW | O_RW);
                step();
            end else if (vecs[i].exp_next == 3'd4) begin
                bus.intr = 1'b0;
                #1;
                check($sformatf("vec%0d_intr_outs", i), outs_w, O_INT | O_PCW);
                step();
            end
            check($sformatf("vec%0d_back_fetch", i), bus.state, 3'd1);
        end

        // An intr pulse confined to FETCH is lost.
        bus.opcode = 7'b0010011;
        bus.funct3 = 3'd0;
        bus.intr = 1'b1;
        #1;
        check("pulse_fetch_state", bus.state, 3'd1);
        step();
        bus.intr = 1'b0;
        #1;
        check("pulse_exec_state", bus.state, 3'd2);
        step();
        check("pulse_lost", bus.state, 3'd1);

        // Reset during the WB of a load abandons it.
        bus.opcode = LOAD;
        bus.funct3 = 3'b010;
        step();
        step();
        check("lw_wb_state", bus.state, 3'd3);
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        check("rst_wb_state", bus.state, 3'd0);
        check("rst_wb_outs", outs_w, O_RST);
        repeat (INIT_N) step();
        check("rst_wb_refetch", bus.state, 3'd1);

`ifdef OTTER_MEM_WAIT_EN
        // FETCH stalls on mem_ready.
        bus.opcode = 7'b0110011;
        bus.funct3 = 3'd0;
        bus.intr = 1'b0;
        set_rdy(1'b0);
        for (int i = 0; i < 3; i++) begin
            #1;
            check($sformatf("wait%0d_state", i), bus.state, 3'd1);
            check($sformatf("wait%0d_outs", i), outs_w, O_RD1);
            step();
        end
        set_rdy(1'b1);
        step();
        check("wait_advance", bus.state, 3'd2);
        step();
        check("wait_back_fetch", bus.state, 3'd1);
`endif

        // Random instruction streams against a per-instruction cycle schedule.
        for (int n = 0; n < 60; n++) begin
            logic [6:0] op;
            logic [2:0] f3;
            logic       fin;
            int         w;
            op = ops[$urandom_range(0, 11)];
            if ($urandom_range(0, 7) == 0) op = 7'($urandom);
            f3 = 3'($urandom);
            fin = ($urandom_range(0, 2) == 0);
            sched.delete();
            w = n_waits();
            repeat (w) sched.push_back('{3'd1, O_RD1, rbit(), 1'b0});
            sched.push_back('{3'd1, O_RD1, rbit(), 1'b1});
            if (op == LOAD) begin
                w = n_waits();
                repeat (w) sched.push_back('{3'd2, O_RD2, rbit(), 1'b0});
                sched.push_back('{3'd2, O_RD2, rbit(), 1'b1});
                sched.push_back('{3'd3, O_PCW | O_RW, fin, rbit()});
            end else if (op == STORE) begin
                w = n_waits();
                repeat (w) sched.push_back('{3'd2, O_WE2, rbit(), 1'b0});
                sched.push_back('{3'd2, O_WE2 | O_PCW, fin, 1'b1});
            end else begin
                sched.push_back('{3'd2, exec_outs(op, f3), fin, rbit()});
            end
            if (fin) sched.push_back('{3'd4, O_INT | O_PCW, rbit(), rbit()});
            bus.opcode = op;
            bus.funct3 = f3;
            foreach (sched[i]) begin
                bus.intr = sched[i].intr;
                set_rdy(sched[i].rdy);
                #1;
                check($sformatf("rnd%0d_c%0d_state", n, i), bus.state, sched[i].st);
                check($sformatf("rnd%0d_c%0d_outs", n, i), outs_w, sched[i].outs);
                step();
            end
        end
        #1;
        check("rnd_end_fetch", bus.state, 3'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
